// File: rtl/gate_sensor_decoder.sv
// rtl/gate_sensor_decoder.sv - gate beam sequence decoder producing inc/dec pulses for the occupancy counter
// Two-flop sync, per-beam debounce, entry/exit sequence FSM with stall timeout and capacity gating.
module gate_sensor_decoder #(
  parameter int COUNT_W         = 4,
  parameter int MAX_SPACES      = 15,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_a,
  input  logic               sensor_b,
  input  logic [COUNT_W-1:0] count,
  output logic               inc,
  output logic               dec,
  output logic               reject,
  output logic               seq_error,
  output logic               full,
  output logic               empty
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLEAR} state_t;

  // Bit 1 tracks the outer beam (a), bit 0 the inner beam (b).
  logic [1:0]    sync1, sync2, ab;
  logic [7:0]    dcnt [2];
  state_t        state, nxt;
  logic [TW-1:0] tcount;
  logic          stalled;

  assign full  = (count == COUNT_W'(MAX_SPACES));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      ab      <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= {sensor_a, sensor_b};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != ab[i]) begin
          if (dcnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
            ab[i]   <= sync2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + 8'd1;
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  function automatic state_t next_of(input state_t s, input logic [1:0] v);
    next_of = s;
    case (s)
      IDLE: case (v)
        2'b10:   next_of = EN1;
        2'b01:   next_of = EX1;
        2'b11:   next_of = WAIT_CLEAR;
        default: next_of = IDLE;
      endcase
      EN1: case (v)
        2'b11:   next_of = EN2;
        2'b00:   next_of = IDLE;
        2'b01:   next_of = WAIT_CLEAR;
        default: next_of = EN1;
      endcase
      EN2: case (v)
        2'b01:   next_of = EN3;
        2'b10:   next_of = EN1;
        2'b00:   next_of = WAIT_CLEAR;
        default: next_of = EN2;
      endcase
      EN3: case (v)
        2'b11:   next_of = EN2;
        2'b10:   next_of = WAIT_CLEAR;
        2'b00:   next_of = IDLE;
        default: next_of = EN3;
      endcase
      EX1: case (v)
        2'b11:   next_of = EX2;
        2'b00:   next_of = IDLE;
        2'b10:   next_of = WAIT_CLEAR;
        default: next_of = EX1;
      endcase
      EX2: case (v)
        2'b10:   next_of = EX3;
        2'b01:   next_of = EX1;
        2'b00:   next_of = WAIT_CLEAR;
        default: next_of = EX2;
      endcase
      EX3: case (v)
        2'b11:   next_of = EX2;
        2'b01:   next_of = WAIT_CLEAR;
        2'b00:   next_of = IDLE;
        default: next_of = EX3;
      endcase
      default: next_of = (v == 2'b00) ? IDLE : WAIT_CLEAR;
    endcase
  endfunction

  assign nxt     = next_of(state, ab);
  assign stalled = (state != IDLE) && (state != WAIT_CLEAR) && (nxt == state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tcount    <= '0;
      inc       <= 1'b0;
      dec       <= 1'b0;
      reject    <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      inc       <= 1'b0;
      dec       <= 1'b0;
      reject    <= 1'b0;
      seq_error <= 1'b0;
      if (stalled) begin
        if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= WAIT_CLEAR;
          seq_error <= 1'b1;
          tcount    <= '0;
        end else begin
          tcount <= tcount + 1'b1;
        end
      end else begin
        state  <= nxt;
        tcount <= '0;
        if (nxt == WAIT_CLEAR && state != WAIT_CLEAR) seq_error <= 1'b1;
        // Capacity is judged on the completing edge, not when the car first broke a beam.
        if (state == EN3 && nxt == IDLE) begin
          if (full) reject <= 1'b1;
          else      inc    <= 1'b1;
        end
        if (state == EX3 && nxt == IDLE) begin
          if (empty) reject <= 1'b1;
          else       dec    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb/tb_gate_sensor_decoder.sv - table-driven and randomized checks of gate_sensor_decoder
// Reference model tracks position along the entry/exit beam paths and a raw-sample history.
module tb_gate_sensor_decoder;
  localparam int D    = 4;
  localparam int TO   = 50;
  localparam int MAXS = 15;

  logic       clk = 1'b0;
  logic       reset, sensor_a, sensor_b;
  logic [3:0] count;
  logic       inc, dec, reject, seq_error, full, empty;

  always #5 clk = ~clk;

  gate_sensor_decoder #(
    .COUNT_W(4), .MAX_SPACES(MAXS), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b), .count(count),
    .inc(inc), .dec(dec), .reject(reject), .seq_error(seq_error), .full(full), .empty(empty)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] hist [16];
  logic [1:0] mdb;
  int         mdir, mpos, mstall;
  bit         mwait;
  bit         e_inc, e_dec, e_rej, e_err;
  int         st_inc, st_dec, st_rej, st_err;

  function automatic logic [1:0] path_ab(input int dir, input int i);
    logic [7:0] s;
    s = (dir == 1) ? 8'b00_10_11_01 : 8'b00_01_11_10;
    return s[7 - 2*i -: 2];
  endfunction

  function automatic int path_pos(input int dir, input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (path_ab(dir, i) == v) return i;
    return 0;
  endfunction

  task automatic model_step(input logic a, input logic b, input logic [3:0] c, input logic r);
    int  p;
    bit  all;
    e_inc = 0; e_dec = 0; e_rej = 0; e_err = 0;
    if (r) begin
      for (int k = 0; k < 16; k++) hist[k] = 2'b00;
      mdb = 2'b00; mdir = 0; mpos = 0; mstall = 0; mwait = 0;
      return;
    end
    if (mwait) begin
      if (mdb == 2'b00) mwait = 0;
    end else if (mpos == 0) begin
      if (mdb == 2'b10)      begin mdir = 1; mpos = 1; mstall = 0; end
      else if (mdb == 2'b01) begin mdir = 2; mpos = 1; mstall = 0; end
      else if (mdb == 2'b11) begin mwait = 1; e_err = 1; end
    end else begin
      p = path_pos(mdir, mdb);
      if (p == mpos) begin
        mstall++;
        if (mstall == TO) begin mwait = 1; e_err = 1; mpos = 0; mstall = 0; end
      end else if (p == 0 && mpos == 3) begin
        mpos = 0;
        if (mdir == 1) begin if (c == MAXS) e_rej = 1; else e_inc = 1; end
        else           begin if (c == 0)    e_rej = 1; else e_dec = 1; end
      end else if (p - mpos == 1 || mpos - p == 1) begin
        mpos = p; mstall = 0;
      end else begin
        mwait = 1; e_err = 1; mpos = 0; mstall = 0;
      end
    end
    // A beam flips once the last D synchronised samples all disagree with it.
    for (int bi = 0; bi < 2; bi++) begin
      all = 1;
      for (int k = 1; k <= D; k++) if (hist[k][bi] == mdb[bi]) all = 0;
      if (all) mdb[bi] = ~mdb[bi];
    end
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {a, b};
  endtask

  task automatic tick(input logic a, input logic b, input logic [3:0] c, input logic r);
    logic [5:0] got, exp;
    sensor_a = a; sensor_b = b; count = c; reset = r;
    @(posedge clk);
    model_step(a, b, c, r);
    @(negedge clk);
    got = {inc, dec, reject, seq_error, full, empty};
    exp = {e_inc, e_dec, e_rej, e_err, c == 4'(MAXS), c == 4'd0};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL tick t=%0t {inc,dec,reject,seq_error,full,empty} got %b expected %b", $time, got, exp);
    end
    st_inc += int'(inc); st_dec += int'(dec); st_rej += int'(reject); st_err += int'(seq_error);
  endtask

  typedef struct {
    logic       a, b, r;
    logic [3:0] c;
    int         hold;
    int         ei, ed, er, ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a, input logic b, input logic r, input logic [3:0] c, input int hold,
                     input int ei, input int ed, input int er, input int ee);
    vec_t v;
    v.a = a; v.b = b; v.r = r; v.c = c; v.hold = hold;
    v.ei = ei; v.ed = ed; v.er = er; v.ee = ee;
    tbl.push_back(v);
  endtask

  initial begin
    logic [1:0] cur, nab;
    logic [3:0] c;
    int         h, sel;

    add(0,0,1, 3, 3, 0,0,0,0);
    // entry at count 3
    add(0,0,0, 3,10, 0,0,0,0); add(1,0,0, 3,10, 0,0,0,0); add(1,1,0, 3,10, 0,0,0,0);
    add(0,1,0, 3,10, 0,0,0,0); add(0,0,0, 3,10, 1,0,0,0);
    // exit at count 5, then aborted entry
    add(0,1,0, 5,10, 0,0,0,0); add(1,1,0, 5,10, 0,0,0,0); add(1,0,0, 5,10, 0,0,0,0);
    add(0,0,0, 5,10, 0,1,0,0);
    add(1,0,0, 5,10, 0,0,0,0); add(0,0,0, 5,10, 0,0,0,0);
    // full entry and empty exit are rejected
    add(1,0,0,15,10, 0,0,0,0); add(1,1,0,15,10, 0,0,0,0); add(0,1,0,15,10, 0,0,0,0);
    add(0,0,0,15,10, 0,0,1,0);
    add(0,1,0, 0,10, 0,0,0,0); add(1,1,0, 0,10, 0,0,0,0); add(1,0,0, 0,10, 0,0,0,0);
    add(0,0,0, 0,10, 0,0,1,0);
    // 3-cycle glitch on a is filtered
    add(1,0,0, 6, 3, 0,0,0,0); add(0,0,0, 6,10, 0,0,0,0);
    // both beams at once is illegal; nothing counts until the gate clears
    add(1,1,0, 6,10, 0,0,0,1); add(1,0,0, 6,10, 0,0,0,0); add(1,1,0, 6,10, 0,0,0,0);
    add(0,1,0, 6,10, 0,0,0,0); add(0,0,0, 6,10, 0,0,0,0);
    // stall in EN2 times out once
    add(1,0,0, 6,10, 0,0,0,0); add(1,1,0, 6,60, 0,0,0,1); add(0,0,0, 6,10, 0,0,0,0);
    // reset in EN3 aborts silently, then a clean entry still counts
    add(1,0,0, 7,10, 0,0,0,0); add(1,1,0, 7,10, 0,0,0,0); add(0,1,0, 7,10, 0,0,0,0);
    add(0,0,1, 7, 2, 0,0,0,0); add(0,0,0, 7,10, 0,0,0,0);
    add(1,0,0, 7,10, 0,0,0,0); add(1,1,0, 7,10, 0,0,0,0); add(0,1,0, 7,10, 0,0,0,0);
    add(0,0,0, 7,10, 1,0,0,0);
    // back-to-back exits with no idle gap beyond the clearing step
    add(0,1,0, 9,10, 0,0,0,0); add(1,1,0, 9,10, 0,0,0,0); add(1,0,0, 9,10, 0,0,0,0);
    add(0,0,0, 9,10, 0,1,0,0);
    add(0,1,0, 9,10, 0,0,0,0); add(1,1,0, 9,10, 0,0,0,0); add(1,0,0, 9,10, 0,0,0,0);
    add(0,0,0, 9,10, 0,1,0,0);

    foreach (tbl[i]) begin
      st_inc = 0; st_dec = 0; st_rej = 0; st_err = 0;
      repeat (tbl[i].hold) tick(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r);
      vectors++;
      if (st_inc != tbl[i].ei || st_dec != tbl[i].ed || st_rej != tbl[i].er || st_err != tbl[i].ee) begin
        miscompares++;
        $display("FAIL step %0d pulse counts inc/dec/reject/seq_error got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                 i, st_inc, st_dec, st_rej, st_err, tbl[i].ei, tbl[i].ed, tbl[i].er, tbl[i].ee);
      end
    end

    cur = 2'b00;
    for (int s = 0; s < 500; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) nab = cur ^ (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      else         nab = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      c = (sel == 0) ? 4'd0 : (sel == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      h = $urandom_range(1, 12);
      if ($urandom_range(0, 49) == 0) tick(cur[1], cur[0], c, 1'b1);
      repeat (h) tick(nab[1], nab[0], c, 1'b0);
      cur = nab;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
